// File: rtl/req_ack_monitor.sv
// req_ack_monitor
//   Multi-channel request/acknowledge protocol monitor. Each channel watches for
//   a rising edge on req_i. It then expects ack_i within the latency window
//   [MIN_LAT, MAX_LAT] cycles after that request. The monitor reports per-channel
//   pass/error pulses, sticky error flags and saturating totals across channels.
//
// Parameters
//   NUM_CH   number of independent channels (1..32)
//   MIN_LAT  earliest legal ack, cycles after the request event (>=1)
//   MAX_LAT  latest legal ack, cycles after the request event (MIN_LAT..255)
//   CNT_W    width of the pass/error totals
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   mon_en_i      monitor enable; low discards attempts and freezes results
//   clr_i         one-cycle pulse clearing sticky flags and totals
//   req_i/ack_i   per-channel request and acknowledge
//   pass_pulse_o  registered one-cycle pass pulse per channel
//   err_pulse_o   registered one-cycle error pulse per channel
//   err_sticky_o  per-channel error flag held until clr_i
//   pass_cnt_o    saturating total of passes
//   err_cnt_o     saturating total of errors
//   err_cause_o   (REQ_ACK_MON_CAUSE_EN only) 2 bits per channel holding the
//                 last error cause: 0 spurious, 1 early, 2 timeout, 3 overlap
//
// Optional feature macro: REQ_ACK_MON_CAUSE_EN

module req_ack_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mon_en_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] pass_pulse_o,
  output logic [NUM_CH-1:0] err_pulse_o,
  output logic [NUM_CH-1:0] err_sticky_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
`ifdef REQ_ACK_MON_CAUSE_EN
  ,
  output logic [2*NUM_CH-1:0] err_cause_o
`endif
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  // A popcount of up to 32 channels needs 6 bits on top of the total width.
  localparam int SUM_W = CNT_W + 6;
  localparam logic [LAT_W-1:0] MIN_L   = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L   = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [LAT_W-1:0] lat_q   [NUM_CH];
  logic [LAT_W-1:0] lat_d   [NUM_CH];

  logic [NUM_CH-1:0] reqPrev_q;
  logic [NUM_CH-1:0] reqEvent;
  logic [NUM_CH-1:0] passEv;
  logic [NUM_CH-1:0] errEv;
  logic              resolved;

  logic [NUM_CH-1:0] passPulse_q;
  logic [NUM_CH-1:0] errPulse_q;
  logic [NUM_CH-1:0] errSticky_q;
  logic [NUM_CH-1:0] errSticky_d;
  logic [CNT_W-1:0]  passCnt_q;
  logic [CNT_W-1:0]  passCnt_d;
  logic [CNT_W-1:0]  errCnt_q;
  logic [CNT_W-1:0]  errCnt_d;

  logic [5:0]        passPop;
  logic [5:0]        errPop;
  logic [SUM_W-1:0]  passSum;
  logic [SUM_W-1:0]  errSum;

  // Per-channel next state. A request event that lands on the same edge as a
  // resolving ack/timeout reports that result and restarts the window; an
  // unresolved attempt hit by a new request is an overlap error.
  always_comb begin
    reqEvent = req_i & ~reqPrev_q;
    passEv   = '0;
    errEv    = '0;
    resolved = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      resolved   = 1'b0;
      if (!mon_en_i) begin
        state_d[i] = ST_IDLE;
        lat_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (reqEvent[i]) begin
              state_d[i] = ST_WAIT;
              lat_d[i]   = LAT_ONE;
            end else if (ack_i[i]) begin
              errEv[i] = 1'b1;
            end
          end
          ST_WAIT: begin
            if (ack_i[i]) begin
              resolved = 1'b1;
              if (lat_q[i] < MIN_L) errEv[i]  = 1'b1;
              else                  passEv[i] = 1'b1;
            end else if (lat_q[i] == MAX_L) begin
              resolved = 1'b1;
              errEv[i] = 1'b1;
            end
            if (reqEvent[i]) begin
              state_d[i] = ST_WAIT;
              lat_d[i]   = LAT_ONE;
              if (!resolved) errEv[i] = 1'b1;
            end else if (resolved) begin
              state_d[i] = ST_IDLE;
              lat_d[i]   = '0;
            end else begin
              lat_d[i] = lat_q[i] + LAT_ONE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            lat_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Totals add this cycle's popcounts and clamp at all-ones; clr restarts
  // them from zero so the current cycle's events are not lost.
  always_comb begin
    passPop = '0;
    errPop  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      passPop = passPop + 6'(passEv[i]);
      errPop  = errPop + 6'(errEv[i]);
    end
    passSum = SUM_W'(clr_i ? '0 : passCnt_q) + SUM_W'(passPop);
    errSum  = SUM_W'(clr_i ? '0 : errCnt_q) + SUM_W'(errPop);
    passCnt_d   = (passSum > SUM_W'(CNT_MAX)) ? CNT_MAX : passSum[CNT_W-1:0];
    errCnt_d    = (errSum > SUM_W'(CNT_MAX)) ? CNT_MAX : errSum[CNT_W-1:0];
    errSticky_d = clr_i ? errEv : (errSticky_q | errEv);
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        lat_q[i]   <= '0;
      end
      reqPrev_q   <= '0;
      passPulse_q <= '0;
      errPulse_q  <= '0;
      errSticky_q <= '0;
      passCnt_q   <= '0;
      errCnt_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
      reqPrev_q   <= req_i;
      passPulse_q <= passEv;
      errPulse_q  <= errEv;
      errSticky_q <= errSticky_d;
      passCnt_q   <= passCnt_d;
      errCnt_q    <= errCnt_d;
    end
  end

`ifdef REQ_ACK_MON_CAUSE_EN
  logic [1:0]          causeNow [NUM_CH];
  logic [2*NUM_CH-1:0] errCause_q;

  // Cause only matters when errEv is set: in IDLE that is spurious; in WAIT an
  // ack before the window is early, no ack at the window end is timeout, and
  // any remaining error must be an overlap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == ST_IDLE)                       causeNow[i] = 2'd0;
      else if (ack_i[i] && (lat_q[i] < MIN_L))         causeNow[i] = 2'd1;
      else if (!ack_i[i] && (lat_q[i] == MAX_L))       causeNow[i] = 2'd2;
      else                                             causeNow[i] = 2'd3;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      errCause_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (errEv[i]) errCause_q[2*i +: 2] <= causeNow[i];
      end
    end
  end

  assign err_cause_o = errCause_q;
`endif

  assign pass_pulse_o = passPulse_q;
  assign err_pulse_o  = errPulse_q;
  assign err_sticky_o = errSticky_q;
  assign pass_cnt_o   = passCnt_q;
  assign err_cnt_o    = errCnt_q;

endmodule

// File: tb/tb_req_ack_monitor.sv
// Directed testbench for req_ack_monitor. Instance A uses default parameters
// (latency window exactly 1). Instance B uses MIN_LAT=2, MAX_LAT=4, CNT_W=2
// for window and saturation cases. Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point.
module tb_req_ack_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_en;
  logic clr;
  logic [3:0] reqA, ackA, reqB, ackB;
  logic [3:0] passA, errA, stickyA, passB, errB, stickyB;
  logic [7:0] pCntA, eCntA;
  logic [1:0] pCntB, eCntB;
`ifdef REQ_ACK_MON_CAUSE_EN
  logic [7:0] causeA, causeB;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  req_ack_monitor dutA (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mon_en_i     (mon_en),
    .clr_i        (clr),
    .req_i        (reqA),
    .ack_i        (ackA),
    .pass_pulse_o (passA),
    .err_pulse_o  (errA),
    .err_sticky_o (stickyA),
    .pass_cnt_o   (pCntA),
    .err_cnt_o    (eCntA)
`ifdef REQ_ACK_MON_CAUSE_EN
    ,
    .err_cause_o  (causeA)
`endif
  );

  req_ack_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(2)) dutB (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mon_en_i     (mon_en),
    .clr_i        (clr),
    .req_i        (reqB),
    .ack_i        (ackB),
    .pass_pulse_o (passB),
    .err_pulse_o  (errB),
    .err_sticky_o (stickyB),
    .pass_cnt_o   (pCntB),
    .err_cnt_o    (eCntB)
`ifdef REQ_ACK_MON_CAUSE_EN
    ,
    .err_cause_o  (causeB)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive both instances for one clock, then settle just past the edge.
  task automatic applyStimulus(input logic [3:0] rA, input logic [3:0] aA,
                               input logic [3:0] rB, input logic [3:0] aB);
    reqA = rA;
    ackA = aA;
    reqB = rB;
    ackB = aB;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] anyPulse;
    rst_n = 1'b0;
    mon_en = 1'b1;
    clr = 1'b0;
    reqA = '0; ackA = '0; reqB = '0; ackB = '0;
    #1;
    checkOutput("rst_passA", passA, 4'h0);
    checkOutput("rst_errA", errA, 4'h0);
    checkOutput("rst_stickyA", stickyA, 4'h0);
    checkOutput("rst_pCntA", pCntA, 8'd0);
    checkOutput("rst_eCntA", eCntA, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

    // A ch0: request then ack one cycle later passes.
    applyStimulus(4'b0001, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'b0001, 4'h0, 4'h0);
    checkOutput("A_pass_pulse", passA, 4'b0001);
    checkOutput("A_pass_noerr", errA, 4'h0);
    checkOutput("A_pass_cnt", pCntA, 8'd1);
    checkOutput("A_pass_ecnt", eCntA, 8'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("A_pass_onecycle", passA, 4'h0);

    // A ch1: no ack -> timeout.
    applyStimulus(4'b0010, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("A_tmo_pulse", errA, 4'b0010);
    checkOutput("A_tmo_sticky", stickyA, 4'b0010);
    checkOutput("A_tmo_ecnt", eCntA, 8'd1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("A_tmo_onecycle", errA, 4'h0);

    // A ch3: ack with no request -> spurious.
    applyStimulus(4'h0, 4'b1000, 4'h0, 4'h0);
    checkOutput("A_spur_pulse", errA, 4'b1000);
    checkOutput("A_spur_sticky", stickyA, 4'b1010);
    checkOutput("A_spur_ecnt", eCntA, 8'd2);
    checkOutput("A_spur_pcnt", pCntA, 8'd1);
`ifdef REQ_ACK_MON_CAUSE_EN
    checkOutput("A_cause_spur", causeA[7:6], 2'd0);
    checkOutput("A_cause_tmo", causeA[3:2], 2'd2);
`endif
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

    // B ch2: ack at lat=1 is early.
    applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'b0100);
    checkOutput("B_early_err", errB, 4'b0100);
    checkOutput("B_early_nopass", passB, 4'h0);
`ifdef REQ_ACK_MON_CAUSE_EN
    checkOutput("B_cause_early", causeB[5:4], 2'd1);
`endif

    // B ch2: ack at lat=3 passes.
    applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'b0100);
    checkOutput("B_lat3_pass", passB, 4'b0100);
    checkOutput("B_lat3_noerr", errB, 4'h0);

    // B ch2: no ack -> timeout exactly at lat=4.
    applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
    repeat (3) applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("B_tmo_notyet", errB, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("B_tmo_err", errB, 4'b0100);
`ifdef REQ_ACK_MON_CAUSE_EN
    checkOutput("B_cause_tmo", causeB[5:4], 2'd2);
`endif

    // B ch2: second request at lat=2 -> overlap, then pass on restarted window.
    applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
    checkOutput("B_ovl_err", errB, 4'b0100);
`ifdef REQ_ACK_MON_CAUSE_EN
    checkOutput("B_cause_ovl", causeB[5:4], 2'd3);
`endif
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'b0100);
    checkOutput("B_ovl_pass", passB, 4'b0100);
    checkOutput("B_ecnt3", eCntB, 2'd3);
    checkOutput("B_pcnt2", pCntB, 2'd2);

    // Three more passes: total 5 saturates the 2-bit counter at 3.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(4'h0, 4'h0, 4'b0100, 4'h0);
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
      applyStimulus(4'h0, 4'h0, 4'h0, 4'b0100);
    end
    checkOutput("B_pcnt_sat", pCntB, 2'd3);
    checkOutput("B_sticky", stickyB, 4'b0100);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

    // A ch0 in WAIT, then disable: attempt discarded, no timeout.
    applyStimulus(4'b0001, 4'h0, 4'h0, 4'h0);
    mon_en = 1'b0;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("dis_noerr", errA, 4'h0);
    checkOutput("dis_ecnt", eCntA, 8'd2);
    mon_en = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("reen_noerr", errA, 4'h0);

    // req already high when enable rises: no request event.
    mon_en = 1'b0;
    applyStimulus(4'b0010, 4'h0, 4'h0, 4'h0);
    mon_en = 1'b1;
    applyStimulus(4'b0010, 4'h0, 4'h0, 4'h0);
    anyPulse = errA | passA;
    applyStimulus(4'b0010, 4'h0, 4'h0, 4'h0);
    anyPulse = anyPulse | errA | passA;
    checkOutput("held_req_noevent", anyPulse, 4'h0);
    checkOutput("held_req_ecnt", eCntA, 8'd2);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);

    // clr wipes sticky flags and totals.
    clr = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    clr = 1'b0;
    checkOutput("clr_stickyA", stickyA, 4'h0);
    checkOutput("clr_stickyB", stickyB, 4'h0);
    checkOutput("clr_pCntA", pCntA, 8'd0);
    checkOutput("clr_eCntB", eCntB, 2'd0);

    // Reset in the middle of an attempt with a pulse showing.
    applyStimulus(4'b0001, 4'h0, 4'h0, 4'b1000);
    checkOutput("pre_rst_errB", errB, 4'b1000);
    checkOutput("pre_rst_eCntB", eCntB, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_errB", errB, 4'h0);
    checkOutput("mid_rst_stickyB", stickyB, 4'h0);
    checkOutput("mid_rst_eCntB", eCntB, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("post_rst_noerrA", errA, 4'h0);
    checkOutput("post_rst_eCntA", eCntA, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
